se_sram_srw_master: RTL and testbench
=====================================

Name: se_sram_srw_master

Overview:
- Initiator-side controller for the single-port synchronous SRAM (se_sram_srw family). It drives select/read_not_write/write_enable/address/write_data.
- Accepts read/write requests from a client over a valid/ack handshake and absorbs the one-cycle SRAM read latency.
- Returns read data through a 2-entry response FIFO with backpressure.
- Includes a clear sequencer that fills the whole SRAM with a constant value.
- Sits between a bus/client and one se_sram_srw_* instance, on the same clock and clock enable.

Parameters:
- address_width, 16, SRAM address bits; the array holds 2^address_width words.
- data_width, 8, SRAM word width.

Ports:
- sram_clock  input  1  clock shared with the SRAM.
- reset_n  input  1  reset, asynchronous, active-low.
- sram_clock__enable  input  1  global clock enable; no state changes while low.
- req_valid  input  1  client request present.
- req_read_not_write  input  1  1 = read, 0 = write.
- req_address  input  address_width  request address.
- req_write_data  input  data_width  write data.
- req_ack  output  1  request accepted this cycle (combinational).
- resp_valid  output  1  response FIFO head valid.
- resp_data  output  data_width  response FIFO head data.
- resp_ack  input  1  client pops the head when resp_valid is high.
- clear_start  input  1  pulse: begin clear sequence.
- clear_value  input  data_width  fill value, sampled when clear_start is taken.
- busy  output  1  clear sequence in progress.
- sram_select  output  1  to SRAM select.
- sram_read_not_write  output  1  to SRAM read_not_write.
- sram_write_enable  output  1  to SRAM write_enable.
- sram_address  output  address_width  to SRAM address.
- sram_write_data  output  data_width  to SRAM write_data.
- sram_data_out  input  data_width  from SRAM data_out.

Behaviour:
- Reset values: state IDLE, FIFO empty, in_flight 0, clear counter 0. Outputs req_ack=0, resp_valid=0, resp_data=0, busy=0, all sram_* = 0.
- Clock enable: every register advances only on a rising sram_clock edge with sram_clock__enable=1. Combinational outputs still follow their inputs.
- States:
  - IDLE: clear_start=1 -> CLEAR. The clear counter loads 0 and clear_value is latched. clear_start has priority over req_valid in the same cycle; no request is acked that cycle.
  - CLEAR: busy=1, req_ack=0. Each enabled cycle issues a write of the latched value at the counter, then increments the counter. A write issued at address 2^address_width-1 -> IDLE, counter wraps to 0. clear_start while in CLEAR is ignored.
- Request acceptance, IDLE only:
  - Writes: req_ack = req_valid & sram_clock__enable.
  - Reads: additionally require (fifo_count + in_flight - pop) < 2, where pop = resp_valid & resp_ack.
- SRAM drive (combinational):
  - When a request is acked: sram_select=1, sram_read_not_write=req_read_not_write, sram_write_enable=!req_read_not_write, address and data passed through.
  - In CLEAR: select=1, read_not_write=0, write_enable=1.
  - Otherwise all sram_* = 0.
- Read pipeline:
  - Read acked at edge N -> in_flight=1 during cycle N+1, when sram_data_out is valid.
  - sram_data_out is pushed into the FIFO at the next enabled edge.
  - resp_valid rises the cycle after that push. Latency from req_ack to resp_valid is 2 enabled cycles.
  - in_flight clears on the push unless a new read was acked the same cycle.
- FIFO:
  - Depth 2, in order; push and pop in the same cycle are both honoured.
  - Overflow is impossible by the acceptance rule. Popping when empty is ignored.
- Ordering: requests complete in acceptance order. A read after a write to the same address in back-to-back cycles returns the new data.
- Reset mid-operation: a clear in progress aborts (SRAM contents are undefined). The FIFO and in_flight are discarded, and no stale resp_valid appears after release.

Decomposition:
- Shared package: state encoding (IDLE, CLEAR) and the FIFO depth constant (2).
- One sub-module, se_sram_resp_fifo (2-entry, data_width, push/pop/count, async active-low reset).

Test Plan:
- Write 0xA5 to addr 0x0010, then read 0x0010 -> req_ack on both; resp_valid 2 cycles after the read ack with resp_data=0xA5.
- Back-to-back reads of 0x0001..0x0004 (preloaded 0x11..0x44), resp_ack held 1 -> one ack per cycle, responses 0x11,0x22,0x33,0x44 in order.
- Reads with resp_ack=0 -> exactly 2 reads acked, then req_ack=0. A single resp_ack pulse -> one further read acked.
- address_width=4, clear_start with clear_value=0x5A -> busy high for exactly 16 enabled cycles, addresses 0..15 written, 0 reads back 0x5A. req_valid held throughout is not acked until busy falls.
- sram_clock__enable toggling 1,0,1,0 during a read -> state frozen on disabled cycles; latency becomes 2 enabled cycles and the data is correct.
- reset_n asserted mid-clear at counter 7 and with one response pending -> busy=0, resp_valid=0 immediately; after release, a normal read works.

Source files
------------

// File: rtl/se_sram_srw_master_pkg.sv
// Shared definitions for the se_sram_srw master: FSM encoding and response FIFO sizing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package se_sram_srw_master_pkg;

    // Response FIFO depth; with one read in flight this bounds outstanding reads to two.
    localparam int RESP_FIFO_DEPTH = 2;
    // Count width able to hold 0..RESP_FIFO_DEPTH.
    localparam int RESP_FIFO_CNT_W = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } master_state_t;

    // True when one more read can be accepted without overflowing the response FIFO.
    // Counts stored entries plus the read currently in the SRAM pipe, minus an entry
    // leaving this cycle.
    function automatic logic read_has_room(
        input logic [RESP_FIFO_CNT_W-1:0] fifo_count,
        input logic                       in_flight,
        input logic                       pop
    );
        logic [RESP_FIFO_CNT_W:0] occupancy;
        occupancy = {1'b0, fifo_count} + {{RESP_FIFO_CNT_W{1'b0}}, in_flight}
                  - {{RESP_FIFO_CNT_W{1'b0}}, pop};
        return occupancy < (RESP_FIFO_CNT_W + 1)'(RESP_FIFO_DEPTH);
    endfunction

endpackage

// File: rtl/se_sram_resp_fifo.sv
// Two-entry in-order response FIFO holding SRAM read data for the client.
// Latency: a push is visible at the head on the cycle after the push edge.
// Backpressure: head held until popped; pop on empty ignored, push on full without pop dropped.
module se_sram_resp_fifo
    import se_sram_srw_master_pkg::*;
#(
    parameter int data_width = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [data_width-1:0]      push_data_i,
    input  logic                       pop_i,
    output logic [RESP_FIFO_CNT_W-1:0] count_o,
    output logic                       head_vld_o,
    output logic [data_width-1:0]      head_dat_o
);

    logic [data_width-1:0]      mem_q [RESP_FIFO_DEPTH];
    logic                       wr_ptr_q, wr_ptr_d;
    logic                       rd_ptr_q, rd_ptr_d;
    logic [RESP_FIFO_CNT_W-1:0] count_q, count_d;
    logic                       do_push, do_pop;

    assign do_pop  = pop_i & (count_q != '0);
    assign do_push = push_i & ((count_q != RESP_FIFO_CNT_W'(RESP_FIFO_DEPTH)) | do_pop);

    // Next pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + RESP_FIFO_CNT_W'(1);
            2'b01:   count_d = count_q - RESP_FIFO_CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage and pointer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < RESP_FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count_o    = count_q;
    assign head_vld_o = (count_q != '0);
    // Present zero when empty so the client never sees stale data.
    assign head_dat_o = head_vld_o ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/se_sram_srw_master.sv
// Client-side master for a single-port synchronous SRAM, with a whole-array clear sequencer.
// Latency: write accepted in one cycle; read data at the response head 2 enabled cycles after req_ack.
// Backpressure: reads withheld while 2 responses are outstanding; no requests accepted during clear.
module se_sram_srw_master
    import se_sram_srw_master_pkg::*;
#(
    parameter int address_width = 16,
    parameter int data_width    = 8
) (
    input  logic                     sram_clock,
    input  logic                     reset_n,
    input  logic                     sram_clock__enable,
    input  logic                     req_valid,
    input  logic                     req_read_not_write,
    input  logic [address_width-1:0] req_address,
    input  logic [data_width-1:0]    req_write_data,
    output logic                     req_ack,
    output logic                     resp_valid,
    output logic [data_width-1:0]    resp_data,
    input  logic                     resp_ack,
    input  logic                     clear_start,
    input  logic [data_width-1:0]    clear_value,
    output logic                     busy,
    output logic                     sram_select,
    output logic                     sram_read_not_write,
    output logic                     sram_write_enable,
    output logic [address_width-1:0] sram_address,
    output logic [data_width-1:0]    sram_write_data,
    input  logic [data_width-1:0]    sram_data_out
);

    master_state_t              state_q, state_d;
    logic [address_width-1:0]   clr_cnt_q, clr_cnt_d;
    logic [data_width-1:0]      clr_val_q, clr_val_d;
    logic                       in_flight_q, in_flight_d;

    logic [RESP_FIFO_CNT_W-1:0] fifo_count;
    logic                       fifo_head_vld;
    logic [data_width-1:0]      fifo_head_dat;
    logic                       resp_pop;
    logic                       read_room;
    logic                       read_ack;
    logic                       fifo_push;
    logic                       fifo_pop;

    // Client pops only when something is at the head.
    assign resp_pop  = fifo_head_vld & resp_ack;
    assign read_room = read_has_room(fifo_count, in_flight_q, resp_pop);

    // Acceptance: idle only, clear_start wins, reads also need response space.
    // reset_n gating keeps the SRAM bus quiet while reset is held.
    assign req_ack = reset_n & sram_clock__enable & (state_q == ST_IDLE) & ~clear_start
                   & req_valid & (~req_read_not_write | read_room);
    assign read_ack = req_ack & req_read_not_write;

    // The SRAM output is valid during the cycle after a read was issued; capture it then.
    assign fifo_push = sram_clock__enable & in_flight_q;
    assign fifo_pop  = sram_clock__enable & resp_pop;

    // Next-state for the clear sequencer and the read pipe tracker.
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        clr_val_d   = clr_val_q;
        in_flight_d = read_ack;
        case (state_q)
            ST_IDLE: begin
                if (clear_start) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                    clr_val_d = clear_value;
                end
            end
            ST_CLEAR: begin
                // Counter wraps to zero naturally after the last address is written.
                clr_cnt_d = clr_cnt_q + address_width'(1);
                if (clr_cnt_q == '1) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM and pipeline registers, frozen while the clock enable is low.
    always_ff @(posedge sram_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            clr_cnt_q   <= '0;
            clr_val_q   <= '0;
            in_flight_q <= 1'b0;
        end else if (sram_clock__enable) begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            clr_val_q   <= clr_val_d;
            in_flight_q <= in_flight_d;
        end
    end

    // SRAM command mux: an accepted request passes straight through, else the clear write.
    always_comb begin
        sram_select         = 1'b0;
        sram_read_not_write = 1'b0;
        sram_write_enable   = 1'b0;
        sram_address        = '0;
        sram_write_data     = '0;
        if (req_ack) begin
            sram_select         = 1'b1;
            sram_read_not_write = req_read_not_write;
            sram_write_enable   = ~req_read_not_write;
            sram_address        = req_address;
            sram_write_data     = req_write_data;
        end else if (state_q == ST_CLEAR) begin
            sram_select         = 1'b1;
            sram_read_not_write = 1'b0;
            sram_write_enable   = 1'b1;
            sram_address        = clr_cnt_q;
            sram_write_data     = clr_val_q;
        end
    end

    se_sram_resp_fifo #(
        .data_width (data_width)
    ) u_resp_fifo (
        .clk_i       (sram_clock),
        .rst_ni      (reset_n),
        .push_i      (fifo_push),
        .push_data_i (sram_data_out),
        .pop_i       (fifo_pop),
        .count_o     (fifo_count),
        .head_vld_o  (fifo_head_vld),
        .head_dat_o  (fifo_head_dat)
    );

    assign resp_valid = fifo_head_vld;
    assign resp_data  = fifo_head_dat;
    assign busy       = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_se_sram_srw_master.sv
// Self-checking bench for se_sram_srw_master with a behavioural SRAM and a queue-based reference model.
// Latency: n/a.
// Backpressure: exercised through resp_ack and clock-enable stimulus.
module tb_se_sram_srw_master;

    localparam int AW    = 5;
    localparam int DW    = 8;
    localparam int WORDS = 1 << AW;

    logic          sram_clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          sram_clock__enable = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_read_not_write = 1'b0;
    logic [AW-1:0] req_address = '0;
    logic [DW-1:0] req_write_data = '0;
    logic          req_ack;
    logic          resp_valid;
    logic [DW-1:0] resp_data;
    logic          resp_ack = 1'b0;
    logic          clear_start = 1'b0;
    logic [DW-1:0] clear_value = '0;
    logic          busy;
    logic          sram_select;
    logic          sram_read_not_write;
    logic          sram_write_enable;
    logic [AW-1:0] sram_address;
    logic [DW-1:0] sram_write_data;
    logic [DW-1:0] sram_data_out = '0;

    int checks = 0;
    int failures = 0;

    se_sram_srw_master #(.address_width(AW), .data_width(DW)) dut (
        .sram_clock          (sram_clock),
        .reset_n             (reset_n),
        .sram_clock__enable  (sram_clock__enable),
        .req_valid           (req_valid),
        .req_read_not_write  (req_read_not_write),
        .req_address         (req_address),
        .req_write_data      (req_write_data),
        .req_ack             (req_ack),
        .resp_valid          (resp_valid),
        .resp_data           (resp_data),
        .resp_ack            (resp_ack),
        .clear_start         (clear_start),
        .clear_value         (clear_value),
        .busy                (busy),
        .sram_select         (sram_select),
        .sram_read_not_write (sram_read_not_write),
        .sram_write_enable   (sram_write_enable),
        .sram_address        (sram_address),
        .sram_write_data     (sram_write_data),
        .sram_data_out       (sram_data_out)
    );

    always #5 sram_clock = ~sram_clock;

    // Behavioural single-port synchronous SRAM, one-cycle read latency, shares the clock enable.
    logic [DW-1:0] smem [WORDS];
    always @(posedge sram_clock) begin
        if (sram_clock__enable && sram_select) begin
            if (!sram_read_not_write && sram_write_enable) smem[sram_address] <= sram_write_data;
            if (sram_read_not_write) sram_data_out <= smem[sram_address];
        end
    end

    // Reference model: array contents, outstanding responses with the enabled-cycle they appear.
    logic [DW-1:0] model_mem [WORDS];
    logic [DW-1:0] q_data [$];
    int            q_ready [$];
    int            ecyc = 0;
    bit            m_busy = 1'b0;
    int            m_clr_addr = 0;
    logic [DW-1:0] m_clr_val = '0;

    logic [DW-1:0] dut_pops [$];
    int            ack_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_data.delete();
        q_ready.delete();
        m_busy = 1'b0;
        m_clr_addr = 0;
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic step();
        bit            ev, pop_e, ea;
        logic [DW-1:0] ed;
        logic [15:0]   ebus;
        @(negedge sram_clock);
        ev = 1'b0;
        if (reset_n && q_data.size() > 0) ev = (q_ready[0] <= ecyc);
        ed = ev ? q_data[0] : '0;
        pop_e = ev && resp_ack;
        ea = reset_n && sram_clock__enable && !m_busy && !clear_start && req_valid &&
             (!req_read_not_write || (q_data.size() - int'(pop_e)) < 2);
        if (ea)
            ebus = {1'b1, req_read_not_write, !req_read_not_write, req_address, req_write_data};
        else if (m_busy)
            ebus = {1'b1, 1'b0, 1'b1, AW'(m_clr_addr), m_clr_val};
        else
            ebus = '0;
        chk("req_ack", 64'(req_ack), 64'(ea));
        chk("resp_valid", 64'(resp_valid), 64'(ev));
        chk("resp_data", 64'(resp_data), 64'(ed));
        chk("busy", 64'(busy), 64'(m_busy));
        chk("sram_bus", 64'({sram_select, sram_read_not_write, sram_write_enable,
                             sram_address, sram_write_data}), 64'(ebus));
        if (resp_valid && resp_ack) dut_pops.push_back(resp_data);
        if (req_ack) ack_cnt++;
        @(posedge sram_clock);
        if (!reset_n) begin
            model_reset();
        end else if (sram_clock__enable) begin
            if (pop_e) begin
                void'(q_data.pop_front());
                void'(q_ready.pop_front());
            end
            if (ea) begin
                if (req_read_not_write) begin
                    q_data.push_back(model_mem[req_address]);
                    q_ready.push_back(ecyc + 2);
                end else begin
                    model_mem[req_address] = req_write_data;
                end
            end
            if (m_busy) begin
                model_mem[m_clr_addr] = m_clr_val;
                if (m_clr_addr == WORDS - 1) begin
                    m_busy = 1'b0;
                    m_clr_addr = 0;
                end else begin
                    m_clr_addr++;
                end
            end else if (clear_start) begin
                m_busy = 1'b1;
                m_clr_addr = 0;
                m_clr_val = clear_value;
            end
            ecyc++;
        end
        #1;
    endtask

    task automatic do_req(input logic rnw, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid = 1'b1;
        req_read_not_write = rnw;
        req_address = a;
        req_write_data = d;
        step();
        req_valid = 1'b0;
    endtask

    // Wait (bounded) for a response, compare it with a literal, then pop it.
    task automatic wait_resp(input string nm, input logic [DW-1:0] exp);
        int n;
        n = 0;
        while (!resp_valid && n < 10) begin
            step();
            n++;
        end
        chk(nm, 64'({resp_valid, resp_data}), 64'({1'b1, exp}));
        resp_ack = 1'b1;
        step();
        resp_ack = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int n;
        int acks_busy;
        for (int i = 0; i < WORDS; i++) begin
            smem[i] = '0;
            model_mem[i] = '0;
        end

        // Reset state
        req_valid = 1'b1;
        step();
        step();
        chk("rst_outs", 64'({req_ack, resp_valid, resp_data, busy, sram_select, sram_read_not_write,
                             sram_write_enable, sram_address, sram_write_data}), 64'h0);
        req_valid = 1'b0;
        reset_n = 1'b1;
        step();

        // Write then read back with exact latency
        do_req(1'b0, 5'h10, 8'hA5);
        do_req(1'b1, 5'h10, 8'h00);
        chk("t1_not_yet", 64'(resp_valid), 64'h0);
        step();
        chk("t1_resp", 64'({resp_valid, resp_data}), 64'({1'b1, 8'hA5}));
        resp_ack = 1'b1;
        step();
        resp_ack = 1'b0;

        // Back-to-back reads with the client always ready
        do_req(1'b0, 5'h01, 8'h11);
        do_req(1'b0, 5'h02, 8'h22);
        do_req(1'b0, 5'h03, 8'h33);
        do_req(1'b0, 5'h04, 8'h44);
        dut_pops.delete();
        ack_cnt = 0;
        resp_ack = 1'b1;
        for (int i = 1; i <= 4; i++) do_req(1'b1, AW'(i), 8'h00);
        chk("t2_acks", 64'(ack_cnt), 64'd4);
        repeat (4) step();
        resp_ack = 1'b0;
        chk("t2_npops", 64'(dut_pops.size()), 64'd4);
        if (dut_pops.size() == 4)
            chk("t2_order", 64'({dut_pops[0], dut_pops[1], dut_pops[2], dut_pops[3]}), 64'h11223344);

        // Backpressure: only two reads outstanding
        ack_cnt = 0;
        req_valid = 1'b1;
        req_read_not_write = 1'b1;
        req_address = 5'h01;
        repeat (6) step();
        chk("t3_two_acks", 64'(ack_cnt), 64'd2);
        ack_cnt = 0;
        resp_ack = 1'b1;
        step();
        resp_ack = 1'b0;
        chk("t3_one_more", 64'(ack_cnt), 64'd1);
        step();
        req_valid = 1'b0;
        resp_ack = 1'b1;
        repeat (5) step();
        resp_ack = 1'b0;

        // Clock enable toggling during a read
        sram_clock__enable = 1'b0;
        req_valid = 1'b1;
        req_read_not_write = 1'b1;
        req_address = 5'h10;
        step();
        sram_clock__enable = 1'b1;
        step();
        req_valid = 1'b0;
        sram_clock__enable = 1'b0;
        step();
        chk("t5_frozen", 64'(resp_valid), 64'h0);
        sram_clock__enable = 1'b1;
        step();
        chk("t5_resp", 64'({resp_valid, resp_data}), 64'({1'b1, 8'hA5}));
        resp_ack = 1'b1;
        step();
        resp_ack = 1'b0;

        // Clear sequence with a request held throughout
        clear_value = 8'h5A;
        clear_start = 1'b1;
        step();
        req_valid = 1'b1;
        req_read_not_write = 1'b0;
        req_address = 5'h03;
        req_write_data = 8'h77;
        n = 0;
        acks_busy = 0;
        while (busy && n < 100) begin
            if (req_ack) acks_busy++;
            if (n == 3) clear_start = 1'b0;
            step();
            n++;
        end
        clear_start = 1'b0;
        chk("t4_busy_len", 64'(n), 64'(WORDS));
        chk("t4_no_ack_busy", 64'(acks_busy), 64'd0);
        chk("t4_ack_after", 64'(req_ack), 64'h1);
        step();
        req_valid = 1'b0;
        do_req(1'b1, 5'h00, 8'h00);
        wait_resp("t4_rd0", 8'h5A);
        do_req(1'b1, 5'h03, 8'h00);
        wait_resp("t4_rd3", 8'h77);

        // Reset mid-clear with a response pending
        do_req(1'b1, 5'h10, 8'h00);
        step();
        clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        n = 0;
        while (m_clr_addr != 7 && n < 40) begin
            step();
            n++;
        end
        chk("t6_cnt7", 64'(sram_address), 64'd7);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_now", 64'({busy, resp_valid}), 64'h0);
        model_reset();
        step();
        step();
        reset_n = 1'b1;
        repeat (3) step();
        chk("t6_no_stale", 64'(resp_valid), 64'h0);
        do_req(1'b0, 5'h02, 8'h3C);
        do_req(1'b1, 5'h02, 8'h00);
        wait_resp("t6_rd", 8'h3C);

        // Randomized traffic against the model
        repeat (800) begin
            req_valid = 1'($urandom_range(0, 1));
            req_read_not_write = 1'($urandom_range(0, 1));
            req_address = AW'($urandom_range(0, WORDS - 1));
            req_write_data = DW'($urandom_range(0, 255));
            resp_ack = 1'($urandom_range(0, 1));
            sram_clock__enable = ($urandom_range(0, 7) != 0);
            clear_start = ($urandom_range(0, 99) == 0);
            clear_value = DW'($urandom_range(0, 255));
            step();
        end
        req_valid = 1'b0;
        clear_start = 1'b0;
        sram_clock__enable = 1'b1;
        resp_ack = 1'b1;
        repeat (40) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
